alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-004 SHALL have ports req0_ready / req1_ready  output  1  requester N operation accepted this cycle.
REQ-005 SHALL have ports req0_alucode / req1_alucode  input  6  ALU operation code (shared ALU_* codes).
REQ-006 SHALL have ports req0_opr1 / req0_opr2 / req1_opr1 / req1_opr2  input  32  operands.
REQ-007 SHALL have port flush  input  1  discard held result.
REQ-008 SHALL have port rsp_valid  output  1  result register holds a valid result.
REQ-009 SHALL have port rsp_ready  input  1  consumer takes the result.
REQ-010 SHALL have port rsp_id  output  1  requester that issued the held result.
REQ-011 SHALL have port rsp_result  output  32  held ALU result.
REQ-012 SHALL have port rsp_br_taken  output  1  held branch-taken flag.

Function
REQ-013 SHALL have two output-buffer states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-014 SHALL accept a request (can_accept=1) when state is EMPTY, or FULL with rsp_ready=1 in the same cycle.
REQ-015 SHALL assert at most one reqN_ready per cycle; reqN_ready is combinational from valids, can_accept and the priority pointer.
REQ-016 SHALL grant round-robin: one valid request wins; when both are valid, the requester not granted last wins.
REQ-017 SHALL update last_grant only on an accepted transfer.
REQ-018 SHALL drive the single ALU instance from the granted requester's alucode/opr1/opr2 and capture result and branch flag in the output register on the accept edge: latency 1 cycle from accept to rsp_valid.
REQ-019 SHALL transition EMPTY->FULL on accept; FULL->EMPTY on rsp_ready with no accept; FULL->FULL (new data) on rsp_ready with accept; FULL->FULL (data held stable) on rsp_ready=0.
REQ-020 SHALL hold rsp_id/rsp_result/rsp_br_taken unchanged while FULL and rsp_ready=0.
REQ-021 SHALL, on flush=1, force state EMPTY next cycle and deassert both reqN_ready that cycle (no accept); last_grant is unchanged.
REQ-022 SHALL treat flush and rsp_ready asserted together as flush (result dropped, not counted as delivered).
REQ-023 SHALL pass undefined alucodes to the ALU unmodified; the captured result is whatever the ALU produces.

Reset
REQ-024 SHALL on rst=1 set state EMPTY, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_br_taken=0, last_grant=1 (requester 0 wins first tie).
REQ-025 SHALL deassert reqN_ready while rst=1; reset mid-transfer discards the held result.
REQ-026 SHALL give rst priority over flush and all handshakes.

Configuration
REQ-027 SHALL honour macro ALU_ARB_FIXED_PRIO_EN: defined -> requester 0 always wins ties, last_grant unused; undefined -> round-robin per REQ-016.

Structure
REQ-028 SHALL take ALU_* operation codes and ENABLE/DISABLE from the shared define header; add ARB_EMPTY/ARB_FULL state constants there.
REQ-029 SHALL instantiate exactly one existing alu sub-module; no other sub-modules.

Verification
REQ-030 Single request: req0 ALU_ADD 5,7, rsp_ready=1 -> req0_ready same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_result=12, rsp_br_taken=0.
REQ-031 Tie round-robin: both valid for 4 cycles after reset, rsp_ready=1 -> grants 0,1,0,1; rsp_id sequence 0,1,0,1.
REQ-032 Backpressure: FULL with result 0x00000003, rsp_ready=0 for 3 cycles, req1 valid -> req1_ready=0, outputs stable; rsp_ready=1 -> req1 accepted same cycle, new result next cycle.
REQ-033 Branch: req1 ALU_BEQ 9,9 -> rsp_br_taken=1, rsp_result=0, rsp_id=1.
REQ-034 Flush: FULL, flush=1 with req0 valid -> req0_ready=0; next cycle rsp_valid=0; following cycle req0 accepted.
REQ-035 Fixed priority (ALU_ARB_FIXED_PRIO_EN defined): both valid 3 cycles -> grants 0,0,0; reset mid-stream -> rsp_valid=0 next cycle.

Source files
------------

// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared ALU operation codes, flag values and arbiter state constants
//
// Purpose: common definitions imported by the ALU, the arbiter top and its interface users.
// Contents:
//   ENABLE / DISABLE        : single-bit flag values
//   ALU_*                   : 6-bit ALU operation codes
//   arb_state_e             : output-buffer state (ARB_EMPTY / ARB_FULL)
package alu_arbiter_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int ALU_CODE_W = 6;

  localparam logic [ALU_CODE_W-1:0] ALU_ADD  = 6'd0;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB  = 6'd1;
  localparam logic [ALU_CODE_W-1:0] ALU_AND  = 6'd2;
  localparam logic [ALU_CODE_W-1:0] ALU_OR   = 6'd3;
  localparam logic [ALU_CODE_W-1:0] ALU_XOR  = 6'd4;
  localparam logic [ALU_CODE_W-1:0] ALU_SLL  = 6'd5;
  localparam logic [ALU_CODE_W-1:0] ALU_SRL  = 6'd6;
  localparam logic [ALU_CODE_W-1:0] ALU_SRA  = 6'd7;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT  = 6'd8;
  localparam logic [ALU_CODE_W-1:0] ALU_SLTU = 6'd9;
  localparam logic [ALU_CODE_W-1:0] ALU_BEQ  = 6'd16;
  localparam logic [ALU_CODE_W-1:0] ALU_BNE  = 6'd17;
  localparam logic [ALU_CODE_W-1:0] ALU_BLT  = 6'd18;
  localparam logic [ALU_CODE_W-1:0] ALU_BGE  = 6'd19;
  localparam logic [ALU_CODE_W-1:0] ALU_BLTU = 6'd20;
  localparam logic [ALU_CODE_W-1:0] ALU_BGEU = 6'd21;

  typedef enum logic {
    ARB_EMPTY = 1'b0,
    ARB_FULL  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - request/response bundle between two requesters, a consumer and the arbiter
//
// Purpose: groups both request channels and the response channel.
// Modports:
//   slave  : arbiter side (takes requests, produces the response)
//   master : requester/consumer side
// Signals:
//   reqN_valid/reqN_ready/reqN_alucode/reqN_opr1/reqN_opr2 : request channel N (N = 0, 1)
//   flush                                                  : discard held result
//   rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_br_taken     : response channel
interface alu_arbiter_if;
  import alu_arbiter_pkg::*;

  logic                  req0_valid;
  logic                  req0_ready;
  logic [ALU_CODE_W-1:0] req0_alucode;
  logic [31:0]           req0_opr1;
  logic [31:0]           req0_opr2;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [ALU_CODE_W-1:0] req1_alucode;
  logic [31:0]           req1_opr1;
  logic [31:0]           req1_opr2;

  logic                  flush;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_id;
  logic [31:0]           rsp_result;
  logic                  rsp_br_taken;

  modport slave (
    input  req0_valid, req0_alucode, req0_opr1, req0_opr2,
    input  req1_valid, req1_alucode, req1_opr1, req1_opr2,
    input  flush, rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_br_taken
  );

  modport master (
    output req0_valid, req0_alucode, req0_opr1, req0_opr2,
    output req1_valid, req1_alucode, req1_opr1, req1_opr2,
    output flush, rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_br_taken
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - combinational ALU with branch comparison flag
//
// Purpose: computes a 32-bit result or a branch-taken flag for one operation.
// Ports:
//   alucode  in  6   operation code (ALU_*)
//   opr1     in  32  first operand
//   opr2     in  32  second operand (shift amount in [4:0])
//   result   out 32  arithmetic/logic result; 0 for branch compares and unknown codes
//   br_taken out 1   comparison outcome for branch codes; 0 otherwise
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [ALU_CODE_W-1:0] alucode,
  input  logic [31:0]           opr1,
  input  logic [31:0]           opr2,
  output logic [31:0]           result,
  output logic                  br_taken
);

  always_comb begin
    result   = '0;
    br_taken = DISABLE;
    case (alucode)
      ALU_ADD:  result = opr1 + opr2;
      ALU_SUB:  result = opr1 - opr2;
      ALU_AND:  result = opr1 & opr2;
      ALU_OR:   result = opr1 | opr2;
      ALU_XOR:  result = opr1 ^ opr2;
      ALU_SLL:  result = opr1 << opr2[4:0];
      ALU_SRL:  result = opr1 >> opr2[4:0];
      ALU_SRA:  result = $unsigned($signed(opr1) >>> opr2[4:0]);
      ALU_SLT:  result = {31'd0, ($signed(opr1) < $signed(opr2))};
      ALU_SLTU: result = {31'd0, (opr1 < opr2)};
      ALU_BEQ:  br_taken = (opr1 == opr2) ? ENABLE : DISABLE;
      ALU_BNE:  br_taken = (opr1 != opr2) ? ENABLE : DISABLE;
      ALU_BLT:  br_taken = ($signed(opr1) <  $signed(opr2)) ? ENABLE : DISABLE;
      ALU_BGE:  br_taken = ($signed(opr1) >= $signed(opr2)) ? ENABLE : DISABLE;
      ALU_BLTU: br_taken = (opr1 <  opr2) ? ENABLE : DISABLE;
      ALU_BGEU: br_taken = (opr1 >= opr2) ? ENABLE : DISABLE;
      default:  ;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter sharing one ALU with a single-entry result buffer
//
// Purpose: grants one of two requesters per cycle, runs the granted operation through the
// shared ALU and holds the result until the consumer takes it.
// Ports:
//   clk  in  1  clock, rising edge
//   rst  in  1  synchronous active-high reset
//   bus  slave modport of alu_arbiter_if (request channels, flush, response channel)
// Build option:
//   ALU_ARB_FIXED_PRIO_EN defined   -> requester 0 always wins a tie
//   ALU_ARB_FIXED_PRIO_EN undefined -> round-robin on ties
module alu_arbiter
  import alu_arbiter_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  alu_arbiter_if.slave bus
);

  arb_state_e            state;
  arb_state_e            state_next;
  logic                  can_accept;
  logic                  grant;        // 0 -> requester 0, 1 -> requester 1
  logic                  accept;
  logic                  req0_ready;
  logic                  req1_ready;
  logic [ALU_CODE_W-1:0] sel_alucode;
  logic [31:0]           sel_opr1;
  logic [31:0]           sel_opr2;
  logic [31:0]           alu_result;
  logic                  alu_br_taken;
  logic                  rsp_id;
  logic [31:0]           rsp_result;
  logic                  rsp_br_taken;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic                  last_grant;
`endif

  // Grant is computed even when nothing can be accepted; readies gate it.
  always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    grant = ~bus.req0_valid;
`else
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant;
    end else begin
      grant = ~bus.req0_valid;
    end
`endif
  end

  // A full buffer can take new data only if it drains in the same cycle.
  assign can_accept = !rst && !bus.flush && ((state == ARB_EMPTY) || bus.rsp_ready);
  assign req0_ready = can_accept && bus.req0_valid && !grant;
  assign req1_ready = can_accept && bus.req1_valid && grant;
  assign accept     = req0_ready || req1_ready;

  assign sel_alucode = grant ? bus.req1_alucode : bus.req0_alucode;
  assign sel_opr1    = grant ? bus.req1_opr1    : bus.req0_opr1;
  assign sel_opr2    = grant ? bus.req1_opr2    : bus.req0_opr2;

  alu_arbiter_alu u_alu (
    .alucode  (sel_alucode),
    .opr1     (sel_opr1),
    .opr2     (sel_opr2),
    .result   (alu_result),
    .br_taken (alu_br_taken)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (bus.flush) begin
      state_next = ARB_EMPTY;
    end else if (accept) begin
      state_next = ARB_FULL;
    end else if ((state == ARB_FULL) && bus.rsp_ready) begin
      state_next = ARB_EMPTY;
    end
  end

  // Payload only moves on accept, so it stays stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_br_taken <= DISABLE;
    end else if (accept) begin
      rsp_id       <= grant;
      rsp_result   <= alu_result;
      rsp_br_taken <= alu_br_taken;
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Reset value 1 lets requester 0 win the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant;
    end
  end
`endif

  assign bus.req0_ready   = req0_ready;
  assign bus.req1_ready   = req1_ready;
  assign bus.rsp_valid    = (state == ARB_FULL);
  assign bus.rsp_id       = rsp_id;
  assign bus.rsp_result   = rsp_result;
  assign bus.rsp_br_taken = rsp_br_taken;

endmodule
